// File: rtl/cusio_pkg.sv
// Shared definitions for the Namco-style custom I/O controller:
// bus command codes, stick direction codes and the stick encoder.
package cusio_pkg;

  localparam logic [7:0] CMD_STOP   = 8'h10;
  localparam logic [7:0] CMD_SWITCH = 8'hA1;
  localparam logic [7:0] CMD_CFG    = 8'hC1;
  localparam logic [7:0] CMD_CREDIT = 8'hE1;
  localparam logic [7:0] CMD_READ   = 8'h71;
  localparam logic [7:0] CMD_TEST   = 8'hB1;
  localparam logic [7:0] CMD_DSW    = 8'hD2;

  typedef enum logic [3:0] {
    DIR_UP    = 4'd0,
    DIR_RIGHT = 4'd2,
    DIR_DOWN  = 4'd4,
    DIR_LEFT  = 4'd6,
    DIR_NONE  = 4'd8
  } dir_e;

  // stk = {left,down,right,up}; lowest set bit wins, so up has priority
  function automatic logic [3:0] stk_encode(input logic [3:0] stk);
    if (stk[0])      return DIR_UP;
    else if (stk[1]) return DIR_RIGHT;
    else if (stk[2]) return DIR_DOWN;
    else if (stk[3]) return DIR_LEFT;
    else             return DIR_NONE;
  endfunction

endpackage

// File: rtl/cusio_bin2bcd.sv
// 7-bit binary to two-digit BCD {tens,ones}, combinational add-3/shift.
// Inputs above 99 are not meaningful (no hundreds digit).
module cusio_bin2bcd (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  logic [14:0] sh;

  // double-dabble: correct each BCD digit before every shift
  always_comb begin
    sh = {8'd0, bin};
    for (int i = 0; i < 7; i++) begin
      if (sh[10:7] >= 4'd5)  sh[10:7]  = sh[10:7]  + 4'd3;
      if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
      sh = sh << 1;
    end
    bcd = sh[14:7];
  end

endmodule

// File: rtl/namco_cusio_gen.sv
// Namco-style custom I/O controller: bus command/data decode, per-frame
// input sampling on the VBLK rising edge, coin/credit accounting with
// delayed start deduction, BCD credit readout and a periodic NMI.
// Optional build macro CUSIO_COIN_METER_EN adds the COIN_METER output
// (8-frame pulse per credited coin, retriggerable).
module namco_cusio_gen
  import cusio_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_COINS   = 2,
  parameter int MAX_CREDITS = 99,
  parameter int NMI_PERIOD  = 2400,
  parameter int NMI_WIDTH   = 200,
  parameter int START_DELAY = 4
) (
  input  logic                     CL,
  input  logic                     RESET,
  input  logic                     VBLK,
  input  logic                     SERVICE,
  input  logic [NUM_COINS-1:0]     INP_COIN,
  input  logic [NUM_PLAYERS-1:0]   INP_START,
  input  logic [NUM_PLAYERS-1:0]   INP_BTN,
  input  logic [4*NUM_PLAYERS-1:0] INP_STK,
  input  logic [15:0]              DSW,
  input  logic                     CS,
  input  logic                     WR,
  input  logic [4:0]               AD,
  input  logic [7:0]               DI,
  output logic [7:0]               DO,
  output logic                     NMI
`ifdef CUSIO_COIN_METER_EN
  ,
  output logic [NUM_COINS-1:0]     COIN_METER
`endif
);

  localparam int             CW       = $clog2(NMI_PERIOD);
  localparam logic [CW-1:0]  NMI_LAST = CW'(NMI_PERIOD - 1);
  localparam logic [CW-1:0]  NMI_ON   = CW'(NMI_PERIOD - NMI_WIDTH);
  localparam logic [7:0]     MAXC     = 8'(MAX_CREDITS);

  logic [7:0]  command;
  logic        mode;
  logic        nmi_en;
  logic [CW-1:0] nmi_cnt;

  logic [3:0]  cpc_stg [NUM_COINS];
  logic [3:0]  cpo_stg [NUM_COINS];
  logic [3:0]  cpc     [NUM_COINS];
  logic [3:0]  cpo     [NUM_COINS];
  logic        cfg_valid;

  logic [6:0]  credits;
  logic [6:0]  credits_nx;
  logic [3:0]  coins    [NUM_COINS];
  logic [3:0]  coins_nx [NUM_COINS];
  logic [7:0]  acc;
  logic        free_play;

  logic        vblk_q;
  logic        frame;
  logic [NUM_COINS-1:0]     prev_coin,  coin_rise,  coin_rise_q;
  logic [NUM_PLAYERS-1:0]   prev_start, start_rise, start_dly_q;
  logic [NUM_PLAYERS-1:0]   prev_btn,   btn_rise,   btn_rise_q, btn_held_q;
  logic [4*NUM_PLAYERS-1:0] stk_q;
  logic                     service_q;
  logic [START_DELAY-1:0]   start_sr [NUM_PLAYERS];

  logic [7:0]  credits_bcd;
  logic [3:0]  idx;
  logic [1:0]  sd2, cr2;

`ifdef CUSIO_COIN_METER_EN
  logic [NUM_COINS-1:0] credited;
  logic [3:0]           meter_cnt [NUM_COINS];
`endif

  assign frame      = VBLK & ~vblk_q;
  assign coin_rise  = INP_COIN  & ~prev_coin;
  assign start_rise = INP_START & ~prev_start;
  assign btn_rise   = INP_BTN   & ~prev_btn;
  assign idx        = AD[3:0];
  assign NMI        = nmi_en & (nmi_cnt >= NMI_ON);

  cusio_bin2bcd u_bcd (
    .bin (credits),
    .bcd (credits_bcd)
  );

  // command register, mode flag and NMI enable
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      command <= 8'h00;
      mode    <= 1'b0;
      nmi_en  <= 1'b0;
    end else if (CS && WR && AD[4]) begin
      command <= DI;
      nmi_en  <= (DI != CMD_STOP);
      if (DI == CMD_SWITCH)
        mode <= 1'b1;
      else if (DI == CMD_CFG || DI == CMD_CREDIT)
        mode <= 1'b0;
    end
  end

  // coin table: staged by data writes in config mode, committed by addr 8
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_COINS; i++) begin
        cpc_stg[i] <= 4'd0;
        cpo_stg[i] <= 4'd0;
        cpc[i]     <= 4'd0;
        cpo[i]     <= 4'd0;
      end
      cfg_valid <= 1'b0;
    end else if (CS && WR && !AD[4] && command == CMD_CFG) begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (idx == 4'(2 + 2*i)) cpc_stg[i] <= DI[3:0];
        if (idx == 4'(3 + 2*i)) cpo_stg[i] <= DI[3:0];
      end
      if (idx == 4'd8) begin
        cpc       <= cpc_stg;
        cpo       <= cpo_stg;
        cfg_valid <= 1'b1;
      end
    end
  end

  // free-running NMI phase counter, independent of command writes
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET)
      nmi_cnt <= '0;
    else if (nmi_cnt == NMI_LAST)
      nmi_cnt <= '0;
    else
      nmi_cnt <= nmi_cnt + CW'(1);
  end

  // coin additions in slot order, then start deductions in player order
  always_comb begin
    acc       = {1'b0, credits};
    free_play = cfg_valid && (cpc[0] == 4'd0);
`ifdef CUSIO_COIN_METER_EN
    credited  = '0;
`endif
    for (int i = 0; i < NUM_COINS; i++) begin
      coins_nx[i] = coins[i];
      if (cfg_valid && !free_play && coin_rise[i] && acc < MAXC) begin
        coins_nx[i] = coins[i] + 4'd1;
        if (coins_nx[i] >= cpc[i]) begin
          acc         = acc + {4'd0, cpo[i]};
          coins_nx[i] = 4'd0;
          if (acc > MAXC) acc = MAXC;
`ifdef CUSIO_COIN_METER_EN
          credited[i] = 1'b1;
`endif
        end
      end
    end
    if (free_play) begin
      acc = 8'd2;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (start_sr[p][START_DELAY-1] && acc >= 8'(p + 1))
          acc = acc - 8'(p + 1);
      end
    end
    credits_nx = acc[6:0];
  end

  // VBLK edge detector
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) vblk_q <= 1'b0;
    else       vblk_q <= VBLK;
  end

  // once-per-frame input sampling, status latches and credit update
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      prev_coin   <= '0;
      prev_start  <= '0;
      prev_btn    <= '0;
      coin_rise_q <= '0;
      start_dly_q <= '0;
      btn_rise_q  <= '0;
      btn_held_q  <= '0;
      stk_q       <= '0;
      service_q   <= 1'b0;
      credits     <= 7'd0;
      for (int i = 0; i < NUM_COINS; i++) coins[i] <= 4'd0;
      for (int p = 0; p < NUM_PLAYERS; p++) start_sr[p] <= '0;
    end else if (frame) begin
      prev_coin   <= INP_COIN;
      prev_start  <= INP_START;
      prev_btn    <= INP_BTN;
      coin_rise_q <= coin_rise;
      btn_rise_q  <= btn_rise;
      btn_held_q  <= INP_BTN;
      stk_q       <= INP_STK;
      service_q   <= SERVICE;
      credits     <= credits_nx;
      coins       <= coins_nx;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        start_dly_q[p] <= start_sr[p][START_DELAY-1];
        start_sr[p]    <= (start_sr[p] << 1) | START_DELAY'(start_rise[p]);
      end
    end
  end

  // switch-mode address 0 carries at most two start and two coin bits
  always_comb begin
    sd2 = 2'b00;
    cr2 = 2'b00;
    for (int j = 0; j < NUM_PLAYERS && j < 2; j++) sd2[j] = start_dly_q[j];
    for (int j = 0; j < NUM_COINS && j < 2; j++)   cr2[j] = coin_rise_q[j];
  end

  // combinational read mux
  always_comb begin
    DO = 8'hFF;
    if (AD[4]) begin
      DO = 8'h00;
    end else begin
      case (command)
        CMD_READ: begin
          if (mode) begin
            if (idx == 4'd0) DO = ~{service_q, 1'b0, sd2, 2'b00, cr2};
            for (int p = 0; p < NUM_PLAYERS; p++)
              if (idx == 4'(p + 1))
                DO = ~{2'b00, btn_held_q[p], btn_rise_q[p], stk_q[4*p +: 4]};
          end else begin
            if (idx == 4'd0) DO = credits_bcd;
            for (int p = 0; p < NUM_PLAYERS; p++)
              if (idx == 4'(p + 1))
                DO = {2'b11, ~btn_held_q[p], ~btn_rise_q[p], stk_encode(stk_q[4*p +: 4])};
          end
        end
        CMD_TEST: if (idx <= 4'(NUM_PLAYERS)) DO = 8'h00;
        CMD_DSW: begin
          if (idx == 4'd0) DO = DSW[7:0];
          if (idx == 4'd1) DO = DSW[15:8];
        end
        default: DO = 8'hFF;
      endcase
    end
  end

`ifdef CUSIO_COIN_METER_EN
  // per-slot frame counter, reloaded to 8 on every credited coin
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_COINS; i++) meter_cnt[i] <= 4'd0;
    end else if (frame) begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (credited[i])              meter_cnt[i] <= 4'd8;
        else if (meter_cnt[i] != 4'd0) meter_cnt[i] <= meter_cnt[i] - 4'd1;
      end
    end
  end

  // meter output is high while the counter is running
  always_comb begin
    for (int i = 0; i < NUM_COINS; i++) COIN_METER[i] = (meter_cnt[i] != 4'd0);
  end
`endif

endmodule

// File: tb/tb_namco_cusio_gen.sv
// Directed, table-driven bench for namco_cusio_gen.
module tb_namco_cusio_gen;

  localparam int NP = 2;
  localparam int NC = 2;
  localparam int P  = 60;
  localparam int W  = 10;
  localparam int SD = 4;

  logic          CL = 1'b0;
  logic          RESET = 1'b1;
  logic          VBLK = 1'b0;
  logic          SERVICE = 1'b0;
  logic [NC-1:0] INP_COIN = '0;
  logic [NP-1:0] INP_START = '0;
  logic [NP-1:0] INP_BTN = '0;
  logic [4*NP-1:0] INP_STK = '0;
  logic [15:0]   DSW = 16'hA55A;
  logic          CS = 1'b0;
  logic          WR = 1'b0;
  logic [4:0]    AD = 5'd0;
  logic [7:0]    DI = 8'd0;
  logic [7:0]    DO;
  logic          NMI;
`ifdef CUSIO_COIN_METER_EN
  logic [NC-1:0] coin_meter;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] coin;
    logic [1:0] start;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [34];

  namco_cusio_gen #(
    .NUM_PLAYERS(NP), .NUM_COINS(NC), .MAX_CREDITS(99),
    .NMI_PERIOD(P), .NMI_WIDTH(W), .START_DELAY(SD)
  ) dut (
    .CL(CL), .RESET(RESET), .VBLK(VBLK), .SERVICE(SERVICE),
    .INP_COIN(INP_COIN), .INP_START(INP_START), .INP_BTN(INP_BTN),
    .INP_STK(INP_STK), .DSW(DSW), .CS(CS), .WR(WR), .AD(AD), .DI(DI),
    .DO(DO), .NMI(NMI)
`ifdef CUSIO_COIN_METER_EN
    , .COIN_METER(coin_meter)
`endif
  );

  always #5 CL = ~CL;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge CL);
    CS = 1'b1; WR = 1'b1; AD = a; DI = d;
    @(negedge CL);
    CS = 1'b0; WR = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
    @(negedge CL);
    AD = a;
    #1;
    check(name, DO, exp);
  endtask

  task automatic frame(input logic [1:0] coin, input logic [1:0] start,
                       input logic [1:0] btn, input logic [7:0] stk, input logic svc);
    @(negedge CL);
    INP_COIN = coin; INP_START = start; INP_BTN = btn; INP_STK = stk; SERVICE = svc;
    VBLK = 1'b1;
    repeat (2) @(negedge CL);
    VBLK = 1'b0;
    repeat (2) @(negedge CL);
  endtask

  task automatic run_vec(input int i);
    frame(vt[i].coin, vt[i].start, 2'b00, 8'h00, 1'b0);
    rd_chk($sformatf("vec%0d_credits", i), 5'd0, vt[i].exp);
  endtask

  initial begin
    int hi;
    int lo;
    bit seen;

    // coin/start frame vectors; expected value is BCD credits at addr 0
    vt[0]  = '{2'b01, 2'b00, 8'h01};
    vt[1]  = '{2'b00, 2'b10, 8'h01};
    vt[2]  = '{2'b00, 2'b00, 8'h01};
    vt[3]  = '{2'b00, 2'b00, 8'h01};
    vt[4]  = '{2'b00, 2'b00, 8'h01};
    vt[5]  = '{2'b00, 2'b00, 8'h01};
    vt[6]  = '{2'b01, 2'b00, 8'h02};
    vt[7]  = '{2'b00, 2'b00, 8'h02};
    vt[8]  = '{2'b01, 2'b00, 8'h03};
    vt[9]  = '{2'b00, 2'b11, 8'h03};
    vt[10] = '{2'b00, 2'b00, 8'h03};
    vt[11] = '{2'b00, 2'b00, 8'h03};
    vt[12] = '{2'b00, 2'b00, 8'h03};
    vt[13] = '{2'b00, 2'b00, 8'h00};
    vt[14] = '{2'b10, 2'b00, 8'h00};
    vt[15] = '{2'b00, 2'b00, 8'h00};
    vt[16] = '{2'b10, 2'b00, 8'h03};
    vt[17] = '{2'b00, 2'b00, 8'h03};
    vt[18] = '{2'b10, 2'b00, 8'h03};
    vt[19] = '{2'b00, 2'b00, 8'h03};
    vt[20] = '{2'b10, 2'b00, 8'h06};
    vt[21] = '{2'b00, 2'b00, 8'h06};
    vt[22] = '{2'b11, 2'b00, 8'h29};
    vt[23] = '{2'b00, 2'b00, 8'h29};
    vt[24] = '{2'b11, 2'b00, 8'h52};
    vt[25] = '{2'b00, 2'b00, 8'h52};
    vt[26] = '{2'b11, 2'b00, 8'h75};
    vt[27] = '{2'b00, 2'b00, 8'h75};
    vt[28] = '{2'b11, 2'b00, 8'h98};
    vt[29] = '{2'b00, 2'b00, 8'h98};
    vt[30] = '{2'b11, 2'b00, 8'h99};
    vt[31] = '{2'b00, 2'b00, 8'h99};
    vt[32] = '{2'b01, 2'b00, 8'h99};
    vt[33] = '{2'b00, 2'b00, 8'h99};

    repeat (3) @(negedge CL);
    RESET = 1'b0;

    // reset state
    rd_chk("rst_data", 5'd0, 8'hFF);
    rd_chk("rst_cmdaddr", 5'h10, 8'h00);
    check("rst_nmi", NMI, 1'b0);

    // test / dipswitch / unknown command reads
    wr(5'h10, 8'hB1);
    rd_chk("b1_addr2", 5'd2, 8'h00);
    rd_chk("b1_addr3", 5'd3, 8'hFF);
    wr(5'h10, 8'hD2);
    rd_chk("d2_addr0", 5'd0, 8'h5A);
    rd_chk("d2_addr1", 5'd1, 8'hA5);
    rd_chk("d2_addr2", 5'd2, 8'hFF);
    wr(5'h10, 8'h33);
    rd_chk("unk_addr0", 5'd0, 8'hFF);

    // NMI held low after stop command
    wr(5'h10, 8'h10);
    hi = 0;
    repeat (2*P) begin
      @(negedge CL);
      if (NMI) hi++;
    end
    check("nmi_stop_highs", hi, 0);

    // NMI duty after read command
    wr(5'h10, 8'h71);
    seen = 0;
    for (int k = 0; k < 2*P && !seen; k++) begin
      @(negedge CL);
      if (!NMI) seen = 1;
    end
    check("nmi_low_seen", seen, 1);
    seen = 0;
    for (int k = 0; k < 2*P && !seen; k++) begin
      @(negedge CL);
      if (NMI) seen = 1;
    end
    check("nmi_rise_seen", seen, 1);
    hi = 1;
    for (int k = 0; k < 2*P; k++) begin
      @(negedge CL);
      if (NMI) hi++;
      else break;
    end
    check("nmi_high_run", hi, W);
    lo = 1;
    for (int k = 0; k < 2*P; k++) begin
      @(negedge CL);
      if (!NMI) lo++;
      else break;
    end
    check("nmi_low_run", lo, P - W);
    hi = 0;
    repeat (3*P) begin
      @(negedge CL);
      if (NMI) hi++;
    end
    check("nmi_3period_highs", hi, 3*W);

    // configure: slot0 1 coin/1 credit, slot1 2 coins/3 credits
    wr(5'h10, 8'hC1);
    wr(5'h02, 8'h01);
    wr(5'h03, 8'h01);
    wr(5'h04, 8'h02);
    wr(5'h05, 8'h03);
    wr(5'h08, 8'h00);
    wr(5'h10, 8'hE1);
    wr(5'h10, 8'h71);
    rd_chk("cfg_credits0", 5'd0, 8'h00);

    for (int i = 0; i < 22; i++) run_vec(i);

    // retarget: slot0 15 credits/coin, slot1 8 credits/coin
    wr(5'h10, 8'hC1);
    wr(5'h03, 8'h0F);
    wr(5'h04, 8'h01);
    wr(5'h05, 8'h08);
    wr(5'h08, 8'h00);
    wr(5'h10, 8'hE1);
    wr(5'h10, 8'h71);

    for (int i = 22; i < 34; i++) run_vec(i);

    // status mode player reads: right+down on player 0, button pressed
    frame(2'b00, 2'b00, 2'b01, 8'h06, 1'b0);
    rd_chk("stat_p0_rise", 5'd1, 8'hC2);
    rd_chk("stat_p1_none", 5'd2, 8'hF8);
    frame(2'b00, 2'b00, 2'b01, 8'h06, 1'b0);
    rd_chk("stat_p0_held", 5'd1, 8'hD2);

    // switch mode
    wr(5'h10, 8'hA1);
    wr(5'h10, 8'h71);
    rd_chk("sw_p0", 5'd1, 8'hD9);
    rd_chk("sw_p1", 5'd2, 8'hFF);
    rd_chk("sw_addr3", 5'd3, 8'hFF);
    frame(2'b01, 2'b00, 2'b01, 8'h06, 1'b1);
    rd_chk("sw_addr0_coin_svc", 5'd0, 8'h7E);

    // reset in the middle of a frame
    @(negedge CL);
    AD = 5'd0;
    VBLK = 1'b1;
    #2 RESET = 1'b1;
    #1;
    check("midrst_do", DO, 8'hFF);
    check("midrst_nmi", NMI, 1'b0);
    @(negedge CL);
    VBLK = 1'b0;
    INP_COIN = '0; INP_BTN = '0; INP_STK = '0; SERVICE = 1'b0;
    @(negedge CL);
    RESET = 1'b0;
    wr(5'h10, 8'h71);
    rd_chk("midrst_credits", 5'd0, 8'h00);
    frame(2'b01, 2'b00, 2'b00, 8'h00, 1'b0);
    rd_chk("midrst_nocfg_coin", 5'd0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
